decodificador_2de5_mux: RTL and testbench
=========================================

# decodificador_2de5_mux

Multi-digit 2-of-5 code display driver. Captures DIGITS five-bit 2-of-5 codewords on a load strobe and validates each one, flagging any codeword without exactly two ones. It decodes each digit to a seven-segment pattern and time-multiplexes the digits onto one shared segment bus with per-digit anode enables. It replaces the per-segment combinational decoders with a single clocked, parametrised display front end.

## Interface
- DIGITS, 4: number of codewords/digits, 1..8
- SCAN_DIV, 50000: clock cycles each digit is shown, >=1
- BLANK_CYC, 2: all-off cycles between digits (anti-ghosting), >=1
- LZ_BLANK, 0: 1 = blank leading zero digits, except digit 0

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- code_in  in  5*DIGITS  codewords; digit i = code_in[5i+4:5i], bit 5i+4 = E1 (MSB), bit 5i = E5
- load  in  1  capture strobe, sampled on clk rising edge
- seg  out  7  active-low segments, seg[0]=a … seg[6]=g
- an  out  DIGITS  active-low one-hot digit enable
- err  out  DIGITS  err[i]=1: stored codeword i is not 2-of-5

## Operation
- Codeword map (E1..E5):
  - 0=11000, 1=10010, 2=01001, 3=00110, 4=10001
  - 5=00011, 6=01010, 7=00101, 8=01100, 9=10100
  - Any other value is invalid, including ones that have exactly two ones but are not in the map (none exist; all 10 are mapped).
- Segment patterns, active-high gfedcba: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Invalid digit shows a dash (40). The seg output is the bitwise inverse of the pattern.
- On load=1, all DIGITS codewords are registered and err[i] is recomputed from them. With load=0, the stored codewords and err hold.
- Leading-zero blanking (LZ_BLANK=1):
  - Digit i>0 is blanked (seg=7F) when it and every higher-index digit decode to valid 0.
  - Invalid digits are never blanked.
- Scan FSM, two states:
  - BLANK: an all 1, seg=7F. After BLANK_CYC cycles, go to SHOW.
  - SHOW: an[idx]=0, seg=pattern(stored[idx]). After SCAN_DIV cycles, go to BLANK and set idx=idx+1, wrapping from DIGITS-1 to 0.
- State, idx, an and seg are registers and change on the same edge.
- In SHOW, seg is recomputed every cycle. A load mid-digit therefore takes effect on the displayed pattern immediately, without waiting for the next scan.
- DIGITS=1: idx stays 0. The BLANK/SHOW cycle still runs.

## Timing
- Reset values: state=BLANK, idx=0, counter=0, an=all 1, seg=7F, err=0, stored codewords=0 (displayed as invalid once shown, but err stays 0 until the first load).
- Reset is asynchronous: asserting rst_n low forces the reset values immediately, including mid-SHOW.
- After reset release, the first SHOW (digit 0) starts at rising edge BLANK_CYC.
- One full scan period = DIGITS*(SCAN_DIV+BLANK_CYC) cycles.
- Load latency:
  - err valid on the edge that samples load=1.
  - seg reflects the new codeword one edge later if that digit is being shown.
- load held high re-captures every cycle. No handshake or acknowledgement.
- An is never low for two digits at once. Each digit transition always passes through BLANK.

## Test plan
All scenarios use DIGITS=4, SCAN_DIV=4, BLANK_CYC=1, LZ_BLANK=0 unless stated.

- Reset then idle: rst_n low → an=F, seg=7F, err=0. After release, edge 1: an=E with digit 0 shown. Sequence an=E,E,E,E,F,D,… repeating with period 20.
- Load code_in={01100,00101,10001,11000} (digits 3..0): err=0. While an=E seg=40 (0), an=D seg=19 (4), an=B seg=78 (7), an=7 seg=00 (8).
- Invalid codewords: digit 1 = 11100, digit 2 = 00000 → err=0110. Those digits show seg=3F (dash). Digits 0 and 3 are unaffected.
- Load during SHOW of digit 0, changing 11000→10010: seg changes from 40 to 79 one edge after the load edge. an does not change and the scan counter is not disturbed.
- LZ_BLANK=1 with digits {11000,11000,10010,11000} = 0010:
  - digits 3 and 2 show seg=7F with their anode active;
  - digit 1 shows 79 and digit 0 shows 40;
  - reloading all 11000 blanks digits 3..1 and digit 0 shows 40.
- Async reset mid-SHOW of digit 2 between clock edges: an=F, seg=7F, err=0 immediately. Scanning restarts from digit 0 after release.

Source files
------------

// File: rtl/decodificador_2de5_mux.sv
// 2-of-5 multi-digit display driver.
// Captures codewords, flags invalid ones, scans digits onto one segment bus.
module decodificador_2de5_mux #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 2,
  parameter int LZ_BLANK  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [5*DIGITS-1:0]   code_in,
  input  logic                  load,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic [DIGITS-1:0]     err
);

  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CMAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [0:0] S_BLANK = 1'b0;
  localparam logic [0:0] S_SHOW  = 1'b1;

  localparam logic [4:0] ZERO_CW = 5'b11000;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  logic [0:0]          state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   err_q, err_d;
  logic [5*DIGITS-1:0] code_q, code_d;

  logic [DIGITS-1:0]   blank;
  logic                zrun;
  logic [4:0]          cur;
  logic [6:0]          shown_seg;
  logic [DIGITS-1:0]   an_sel;

  function automatic logic [6:0] pat(input logic [4:0] c);
    unique case (c)
      5'b11000: pat = 7'h3F;
      5'b10010: pat = 7'h06;
      5'b01001: pat = 7'h5B;
      5'b00110: pat = 7'h4F;
      5'b10001: pat = 7'h66;
      5'b00011: pat = 7'h6D;
      5'b01010: pat = 7'h7D;
      5'b00101: pat = 7'h07;
      5'b01100: pat = 7'h7F;
      5'b10100: pat = 7'h6F;
      default:  pat = 7'h40;
    endcase
  endfunction

  // Capture codewords and recompute validity flags on load
  always_comb begin
    code_d = code_q;
    err_d  = err_q;
    if (load) begin
      code_d = code_in;
      for (int i = 0; i < DIGITS; i++) begin
        err_d[i] = ($countones(code_in[5*i +: 5]) != 2);
      end
    end
  end

  // Leading-zero mask: run of valid zeros from the top digit down
  always_comb begin
    zrun  = 1'b1;
    blank = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zrun = zrun & (code_q[5*i +: 5] == ZERO_CW);
      blank[i] = (LZ_BLANK != 0) && (i > 0) && zrun;
    end
  end

  assign cur       = code_q[5*int'(idx_q) +: 5];
  assign shown_seg = blank[idx_q] ? SEG_OFF : ~pat(cur);
  assign an_sel    = ~(DIGITS'(1) << idx_q);

  // Scan FSM: BLANK gap, then SHOW the current digit
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + 1'b1;
    an_d    = an_q;
    seg_d   = seg_q;
    unique case (state_q)
      S_BLANK: begin
        an_d  = '1;
        seg_d = SEG_OFF;
        if (cnt_q == CW'(BLANK_CYC - 1)) begin
          state_d = S_SHOW;
          cnt_d   = '0;
          an_d    = an_sel;
          seg_d   = shown_seg;
        end
      end
      S_SHOW: begin
        an_d  = an_sel;
        seg_d = shown_seg;
        if (cnt_q == CW'(SCAN_DIV - 1)) begin
          state_d = S_BLANK;
          cnt_d   = '0;
          an_d    = '1;
          seg_d   = SEG_OFF;
          if (idx_q == IW'(DIGITS - 1)) begin
            idx_d = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_BLANK;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BLANK;
      idx_q   <= '0;
      cnt_q   <= '0;
      an_q    <= '1;
      seg_q   <= SEG_OFF;
      err_q   <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign err = err_q;

endmodule

// File: tb/tb_decodificador_2de5_mux.sv
// Directed bench for decodificador_2de5_mux.
// Two instances: plain and leading-zero blanking.
module tb_decodificador_2de5_mux;

  logic        clk;
  logic        rst_n;
  logic [19:0] code_in;
  logic        load;
  logic [6:0]  seg, seg_z;
  logic [3:0]  an, an_z;
  logic [3:0]  err, err_z;

  int errors = 0;
  int checks = 0;
  int e = 0;

  decodificador_2de5_mux #(
    .DIGITS(4), .SCAN_DIV(4), .BLANK_CYC(1), .LZ_BLANK(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .code_in(code_in), .load(load),
    .seg(seg), .an(an), .err(err)
  );

  decodificador_2de5_mux #(
    .DIGITS(4), .SCAN_DIV(4), .BLANK_CYC(1), .LZ_BLANK(1)
  ) dut_z (
    .clk(clk), .rst_n(rst_n), .code_in(code_in), .load(load),
    .seg(seg_z), .an(an_z), .err(err_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_an(input int k);
    int p;
    if (k <= 0) return 4'hF;
    p = (k - 1) % 20;
    if (p % 5 == 4) return 4'hF;
    return ~(4'b0001 << (p / 5));
  endfunction

  task automatic tick();
    @(posedge clk);
    e++;
    @(negedge clk);
  endtask

  task automatic goto(input int d);
    logic [3:0] t;
    int n;
    t = ~(4'b0001 << d);
    n = 0;
    tick();
    while (exp_an(e) != t && n < 40) begin
      tick();
      n++;
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    code_in = '0;
    load    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_err", err, 4'h0);
    chk("rst_an_z", an_z, 4'hF);

    rst_n = 1'b1;
    e = 0;
    tick();
    chk("first_an", an, 4'hE);
    chk("first_seg", seg, 7'h3F);
    for (int k = 2; k <= 21; k++) begin
      tick();
      chk($sformatf("scan_an_e%0d", e), an, exp_an(e));
    end

    code_in = {5'b01100, 5'b00101, 5'b10001, 5'b11000};
    load = 1'b1;
    tick();
    load = 1'b0;
    chk("ld_err", err, 4'h0);
    goto(0);
    chk("d0_an", an, 4'hE);
    chk("d0_seg", seg, 7'h40);
    goto(1);
    chk("d1_an", an, 4'hD);
    chk("d1_seg", seg, 7'h19);
    goto(2);
    chk("d2_an", an, 4'hB);
    chk("d2_seg", seg, 7'h78);
    goto(3);
    chk("d3_an", an, 4'h7);
    chk("d3_seg", seg, 7'h00);

    code_in = {5'b01100, 5'b00000, 5'b11100, 5'b11000};
    load = 1'b1;
    tick();
    load = 1'b0;
    chk("inv_err", err, 4'h6);
    goto(0);
    chk("inv_d0", seg, 7'h40);
    goto(1);
    chk("inv_d1", seg, 7'h3F);
    goto(2);
    chk("inv_d2", seg, 7'h3F);
    goto(3);
    chk("inv_d3", seg, 7'h00);

    goto(0);
    chk("mid_pre_seg", seg, 7'h40);
    code_in = {5'b01100, 5'b00101, 5'b10001, 5'b10010};
    load = 1'b1;
    tick();
    load = 1'b0;
    chk("mid_ld_seg", seg, 7'h40);
    chk("mid_ld_an", an, 4'hE);
    chk("mid_ld_err", err, 4'h0);
    tick();
    chk("mid_new_seg", seg, 7'h79);
    chk("mid_new_an", an, 4'hE);
    tick();
    chk("mid_cnt_an3", an, 4'hE);
    tick();
    chk("mid_cnt_blank", an, 4'hF);
    tick();
    chk("mid_cnt_next", an, 4'hD);

    code_in = {5'b11000, 5'b11000, 5'b10010, 5'b11000};
    load = 1'b1;
    tick();
    load = 1'b0;
    chk("lz_err", err_z, 4'h0);
    goto(2);
    chk("lz_d2_an", an_z, 4'hB);
    chk("lz_d2_seg", seg_z, 7'h7F);
    goto(3);
    chk("lz_d3_an", an_z, 4'h7);
    chk("lz_d3_seg", seg_z, 7'h7F);
    chk("nolz_d3_seg", seg, 7'h40);
    goto(0);
    chk("lz_d0_seg", seg_z, 7'h40);
    goto(1);
    chk("lz_d1_seg", seg_z, 7'h79);

    code_in = {5'b11000, 5'b11000, 5'b11000, 5'b11000};
    load = 1'b1;
    tick();
    load = 1'b0;
    goto(2);
    chk("lz0_d2_seg", seg_z, 7'h7F);
    goto(3);
    chk("lz0_d3_seg", seg_z, 7'h7F);
    goto(0);
    chk("lz0_d0_seg", seg_z, 7'h40);
    goto(1);
    chk("lz0_d1_seg", seg_z, 7'h7F);
    chk("lz0_d1_an", an_z, 4'hD);

    code_in = '0;
    load = 1'b1;
    tick();
    load = 1'b0;
    chk("all_inv_err", err, 4'hF);
    goto(2);
    chk("ar_pre_an", an, 4'hB);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_an", an, 4'hF);
    chk("ar_seg", seg, 7'h7F);
    chk("ar_err", err, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    e = 0;
    tick();
    chk("ar_rel_an", an, 4'hE);
    chk("ar_rel_seg", seg, 7'h3F);
    for (int k = 2; k <= 7; k++) begin
      tick();
      chk($sformatf("ar_scan_e%0d", e), an, exp_an(e));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
